// File: rtl/ctrl_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ctrl_mc                                                    |
// | Description : Multi-cycle instruction controller. Steps each instruction |
// |               through FETCH -> EXEC -> (MEMWAIT -> WB) and decodes the   |
// |               datapath strobes from the registered state and IR.         |
// | Ports       : Clk, Reset (sync, active-high), Start/Ack run handshake,   |
// |               Instruction (ROM word), BranchCond (ALU flag),             |
// |               IRWrite/PCEn/WriteR0/GenRegWrite/WriteMem/MemRead/         |
// |               MemToReg/LUTsignal/Branch strobes, Illegal pulse, Busy,    |
// |               InstCount (saturating retired-instruction counter).        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ctrl_mc #(
    parameter int IW      = 9,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [IW-1:0]    Instruction,
    input  logic             BranchCond,
    output logic             IRWrite,
    output logic             PCEn,
    output logic             WriteR0,
    output logic             GenRegWrite,
    output logic             WriteMem,
    output logic             MemRead,
    output logic             MemToReg,
    output logic             LUTsignal,
    output logic             Branch,
    output logic             Illegal,
    output logic             Busy,
    output logic             Ack,
    output logic [CNT_W-1:0] InstCount
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FETCH   = 3'd1;
    localparam logic [2:0] c_EXEC    = 3'd2;
    localparam logic [2:0] c_MEMWAIT = 3'd3;
    localparam logic [2:0] c_WB      = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    // Wide enough for MEM_LAT up to 8.
    localparam logic [3:0] c_WAIT_INIT = 4'(MEM_LAT - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [IW-1:0]    r_ir;
    logic [3:0]       r_wait;
    logic [CNT_W-1:0] r_count;

    // Instruction fields, taken from the top of the IR.
    logic       w_msb;
    logic [3:0] w_rop;
    logic [2:0] w_iop;
    logic       w_halt;

    assign w_msb  = r_ir[IW-1];
    assign w_rop  = r_ir[IW-2 -: 4];
    assign w_iop  = r_ir[IW-2 -: 3];
    assign w_halt = &r_ir;

    // Instruction class decode.
    logic w_load, w_alu, w_lut, w_mvfr, w_str, w_btru, w_b, w_ill;

    always_comb begin
        w_load = 1'b0;
        w_alu  = 1'b0;
        w_lut  = 1'b0;
        w_mvfr = 1'b0;
        w_str  = 1'b0;
        w_btru = 1'b0;
        w_b    = 1'b0;
        w_ill  = 1'b0;
        if (w_halt) begin
            // Halt shares the I-type 3'd7 slot; it must not flag Illegal.
        end else if (!w_msb) begin
            case (w_rop)
                4'd1:        w_load = 1'b1;
                4'd2:        w_mvfr = 1'b1;
                4'd8:        w_str  = 1'b1;
                4'd11:       w_btru = 1'b1;
                4'd14, 4'd15: w_ill = 1'b1;
                default:     w_alu  = 1'b1;
            endcase
        end else begin
            case (w_iop)
                3'd0:        w_lut  = 1'b1;
                3'd3:        w_b    = 1'b1;
                3'd6, 3'd7:  w_ill  = 1'b1;
                default:     w_alu  = 1'b1;
            endcase
        end
    end

    // Output decode. Reset forces every output low in the same cycle so an
    // aborted load emits no strobe.
    logic w_pcen;

    always_comb begin
        IRWrite     = 1'b0;
        w_pcen      = 1'b0;
        WriteR0     = 1'b0;
        GenRegWrite = 1'b0;
        WriteMem    = 1'b0;
        MemRead     = 1'b0;
        MemToReg    = 1'b0;
        LUTsignal   = 1'b0;
        Branch      = 1'b0;
        Illegal     = 1'b0;
        Busy        = 1'b0;
        Ack         = 1'b0;
        if (!Reset) begin
            case (r_state)
                c_FETCH: begin
                    IRWrite = 1'b1;
                    Busy    = 1'b1;
                end
                c_EXEC: begin
                    Busy        = 1'b1;
                    MemRead     = w_load;
                    WriteR0     = w_alu | w_lut;
                    LUTsignal   = w_lut;
                    GenRegWrite = w_mvfr;
                    WriteMem    = w_str;
                    Branch      = w_b | (w_btru & BranchCond);
                    Illegal     = w_ill;
                    w_pcen      = !w_halt && !w_load;
                end
                c_MEMWAIT: begin
                    Busy    = 1'b1;
                    MemRead = 1'b1;
                end
                c_WB: begin
                    Busy     = 1'b1;
                    MemRead  = 1'b1;
                    MemToReg = 1'b1;
                    WriteR0  = 1'b1;
                    w_pcen   = 1'b1;
                end
                c_DONE: begin
                    Ack = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign PCEn      = w_pcen;
    assign InstCount = r_count;

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE, c_DONE: if (Start) w_next = c_FETCH;
            c_FETCH:        w_next = c_EXEC;
            c_EXEC: begin
                if (w_halt)      w_next = c_DONE;
                else if (w_load) w_next = c_MEMWAIT;
                else             w_next = c_FETCH;
            end
            c_MEMWAIT:      if (r_wait == 4'd0) w_next = c_WB;
            c_WB:           w_next = c_FETCH;
            default:        w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_ir    <= '0;
            r_wait  <= 4'd0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == c_FETCH) begin
                r_ir <= Instruction;
            end
            if (r_state == c_EXEC && w_load) begin
                r_wait <= c_WAIT_INIT;
            end else if (r_state == c_MEMWAIT && r_wait != 4'd0) begin
                r_wait <= r_wait - 4'd1;
            end
            // Saturating count of retired instructions.
            if (w_pcen && r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ctrl_mc.md
Name: ctrl_mc

Overview:
- Multi-cycle successor to the single-cycle combinational instruction decoder.
- Sequences each instruction through fetch, execute, memory-wait and writeback states.
- Emits one-cycle write strobes, PC-advance and branch strobes, plus a variable-latency load path, Start/Ack run handshake, illegal-opcode flag and retired-instruction counter.
- Sits between instruction ROM/PC and the RegFile/ALU/DataMem datapath.

Parameters:
- IW, 9, instruction width; legal 9..16. Opcode fields are taken from the top bits.
- MEM_LAT, 1, DataMem read latency in cycles; legal 1..8.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  begin execution; sampled in IDLE and DONE only
- Instruction  in  IW  instruction word from ROM; valid during FETCH
- BranchCond  in  1  ALU condition flag for BTRU; sampled in EXEC
- IRWrite  out  1  latch Instruction into IR
- PCEn  out  1  advance PC (retire current instruction)
- WriteR0  out  1  write accumulator
- GenRegWrite  out  1  write general register
- WriteMem  out  1  DataMem write strobe
- MemRead  out  1  DataMem read enable
- MemToReg  out  1  RegFile input mux selects DataMem
- LUTsignal  out  1  PC target from LUT
- Branch  out  1  PC takes branch target; valid only with PCEn
- Illegal  out  1  one-cycle pulse on undefined opcode
- Busy  out  1  high in every state except IDLE and DONE
- Ack  out  1  program done; held high in DONE
- InstCount  out  CNT_W  retired-instruction count

Behaviour:
- Reset (synchronous, active-high): state=IDLE, IR=0, wait counter=0, InstCount=0; all outputs 0. Reset in any state, including mid-load, aborts with no strobe emitted in that cycle.
- Decode fields from IR:
  - MSB=IR[IW-1]; R_op=IR[IW-2:IW-5]; I_op=IR[IW-2:IW-4].
  - Halt = IR all ones.
- States: IDLE, FETCH, EXEC, MEMWAIT, WB, DONE.
- IDLE: all outputs 0. On Start, go to FETCH.
- FETCH (1 cycle): IRWrite=1; IR<=Instruction at cycle end; go to EXEC.
- EXEC (1 cycle), by decoded class:
  - Halt: no strobes, no PCEn; go to DONE.
  - LOAD (R_op 1): MemRead=1; wait counter<=MEM_LAT-1; go to MEMWAIT.
  - R_op 0,3,4,5,6,7,9,10,12,13 and I_op 1,2,4,5: WriteR0=1, PCEn=1; go to FETCH.
  - I_op 0 (LUT): WriteR0=1, LUTsignal=1, PCEn=1; go to FETCH.
  - MVFR (R_op 2): GenRegWrite=1, PCEn=1; go to FETCH.
  - STR (R_op 8): WriteMem=1, PCEn=1; go to FETCH.
  - BTRU (R_op 11): PCEn=1, Branch=BranchCond; go to FETCH.
  - B (I_op 3): PCEn=1, Branch=1; go to FETCH.
  - Undefined (R_op 14,15; I_op 6,7 non-halt): Illegal=1, PCEn=1, no writes; go to FETCH.
- MEMWAIT: MemRead=1. If counter==0, go to WB; else decrement.
- WB (1 cycle): WriteR0=1, MemToReg=1, MemRead=1, PCEn=1; go to FETCH.
- Cycle counts:
  - Non-load instruction: 2 cycles.
  - LOAD: 3+MEM_LAT cycles.
  - Halt: 2 cycles to DONE.
- DONE: Ack=1, Busy=0. On Start, clear Ack and go to FETCH; PC is not reset by this block.
- All strobes are registered-state decodes and assert for exactly one cycle per instruction, except MemRead, which spans the full load.
- InstCount increments on every PCEn cycle, saturates at 2^CNT_W-1, and is not cleared by Start. Halt is not counted.
- Start outside IDLE/DONE is ignored.
- Instruction is ignored outside FETCH.

Test Plan:
- Reset, Start, Instruction=9'b0_0000_0001 (ADD) -> cycle1 IRWrite=1; cycle2 WriteR0=1, PCEn=1, Branch=0; InstCount=1.
- MEM_LAT=2, Instruction=9'b0_0001_0000 (LOAD) -> MemRead high for 4 cycles (EXEC, 2×MEMWAIT, WB); WB on cycle 5 after FETCH start with WriteR0=1, MemToReg=1, PCEn=1.
- BTRU 9'b0_1011_0000 with BranchCond=0, then BTRU with BranchCond=1, then B 9'b1_0110_0000 -> Branch=0, 1, 1, each coincident with PCEn.
- Instruction=9'b0_1110_0000 -> Illegal=1 for one cycle, PCEn=1, no write strobes; I_op 0 9'b1_0000_0011 -> WriteR0=1, LUTsignal=1.
- Halt 9'h1FF after 3 instructions -> Ack=1 and held, Busy=0, InstCount=3; Start -> Ack=0, IRWrite next cycle; Start pulsed while Busy -> no effect.
- Reset asserted in MEMWAIT -> next cycle IDLE, all outputs 0, InstCount=0; CNT_W=2 with 5 ADDs -> InstCount saturates at 3.
